// File: rtl/svo_pixel_fifo_if.sv
// Stream-side bundle for svo_pixel_fifo: producer beats in, encoder beats out,
// flush request and status. The slave modport is the FIFO's view.
interface svo_pixel_fifo_if #(
    parameter int SVO_BITS_PER_PIXEL = 24,
    parameter int DEPTH_LOG2         = 4
);
    logic                          in_axis_tvalid;
    logic                          in_axis_tready;
    logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata;
    logic                          in_axis_tuser;
    logic                          out_axis_tvalid;
    logic                          out_axis_tready;
    logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata;
    logic                          out_axis_tuser;
    logic                          sync_req;
    logic                          frame_err;
    logic [7:0]                    underflow_cnt;
    logic [DEPTH_LOG2:0]           level;

    modport master (
        output in_axis_tvalid, in_axis_tdata, in_axis_tuser, out_axis_tready, sync_req,
        input  in_axis_tready, out_axis_tvalid, out_axis_tdata, out_axis_tuser,
               frame_err, underflow_cnt, level
    );

    modport slave (
        input  in_axis_tvalid, in_axis_tdata, in_axis_tuser, out_axis_tready, sync_req,
        output in_axis_tready, out_axis_tvalid, out_axis_tdata, out_axis_tuser,
               frame_err, underflow_cnt, level
    );
endinterface

// File: rtl/svo_pixel_fifo.sv
// Elastic first-word-fall-through pixel buffer between the card stream and the
// SVO encoder: aligns to SOF, checks frame length, flushes on sync_req.
module svo_pixel_fifo #(
    parameter int SVO_BITS_PER_PIXEL = 24,
    parameter int DEPTH_LOG2         = 4,
    parameter int FRAME_PIXELS       = 307200
) (
    input logic             clk,
    input logic             resetn,
    svo_pixel_fifo_if.slave bus
);
    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [0:0]  SYNC_WAIT = 1'b0;
    localparam logic [0:0]  RUN       = 1'b1;
    localparam logic [18:0] FRAME_LEN = 19'(FRAME_PIXELS);

    logic [SVO_BITS_PER_PIXEL:0] mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]         level_q, level_d;
    logic [18:0]                 pix_cnt_q, pix_cnt_d;
    logic [0:0]                  state_q, state_d;
    logic                        primed_q, primed_d;
    logic                        frame_err_q, frame_err_d;
    logic [7:0]                  uf_cnt_q, uf_cnt_d;
    logic                        full, empty, in_rdy, accept, push, pop, sof;

    assign full   = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty  = (level_q == '0);
    // tready depends only on registered state, never on an input
    assign in_rdy = (state_q == SYNC_WAIT) | ~full;
    assign accept = bus.in_axis_tvalid & in_rdy & ~bus.sync_req;
    assign sof    = bus.in_axis_tuser;
    assign pop    = ~empty & bus.out_axis_tready & ~bus.sync_req;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        primed_d    = primed_q;
        frame_err_d = 1'b0;
        uf_cnt_d    = uf_cnt_q;
        push        = 1'b0;

        if (accept) begin
            if (state_q == SYNC_WAIT) begin
                if (sof) begin
                    push      = ~full;
                    pix_cnt_d = 19'd1;
                    state_d   = RUN;
                end
            end else if (sof) begin
                push        = 1'b1;
                frame_err_d = (pix_cnt_q != FRAME_LEN);
                pix_cnt_d   = 19'd1;
            end else if (pix_cnt_q == FRAME_LEN) begin
                // overlong frame: drop the beat and wait for the next SOF
                frame_err_d = 1'b1;
                state_d     = SYNC_WAIT;
            end else begin
                push      = 1'b1;
                pix_cnt_d = pix_cnt_q + 19'd1;
            end
        end

        if (pop && state_q == RUN) primed_d = 1'b1;
        if (state_d == SYNC_WAIT) primed_d = 1'b0;

        if (state_q == RUN && primed_q && bus.out_axis_tready && empty && uf_cnt_q != 8'hff)
            uf_cnt_d = uf_cnt_q + 8'd1;

        if (bus.sync_req) begin
            state_d   = SYNC_WAIT;
            primed_d  = 1'b0;
            pix_cnt_d = '0;
        end

        wptr_d  = bus.sync_req ? '0 : wptr_q + DEPTH_LOG2'(push);
        rptr_d  = bus.sync_req ? '0 : rptr_q + DEPTH_LOG2'(pop);
        level_d = bus.sync_req ? '0
                : level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= SYNC_WAIT;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            pix_cnt_q   <= '0;
            primed_q    <= 1'b0;
            frame_err_q <= 1'b0;
            uf_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            pix_cnt_q   <= pix_cnt_d;
            primed_q    <= primed_d;
            frame_err_q <= frame_err_d;
            uf_cnt_q    <= uf_cnt_d;
        end
    end

    // Payload storage needs no reset; empty masks the head output.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {sof, bus.in_axis_tdata};
    end

    assign bus.in_axis_tready  = in_rdy;
    assign bus.out_axis_tvalid = ~empty;
    assign bus.out_axis_tdata  = empty ? '0 : mem_q[rptr_q][SVO_BITS_PER_PIXEL-1:0];
    assign bus.out_axis_tuser  = empty ? 1'b0 : mem_q[rptr_q][SVO_BITS_PER_PIXEL];
    assign bus.frame_err       = frame_err_q;
    assign bus.underflow_cnt   = uf_cnt_q;
    assign bus.level           = level_q;
endmodule

// File: tb/tb_svo_pixel_fifo.sv
// Directed bench for svo_pixel_fifo with a queue scoreboard and a small
// behavioural model of the framing/underflow rules.
module tb_svo_pixel_fifo;
    localparam int BPP   = 24;
    localparam int DL2   = 4;
    localparam int FP    = 8;
    localparam int DEPTH = 1 << DL2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    svo_pixel_fifo_if #(.SVO_BITS_PER_PIXEL(BPP), .DEPTH_LOG2(DL2)) vif();

    svo_pixel_fifo #(
        .SVO_BITS_PER_PIXEL(BPP),
        .DEPTH_LOG2        (DL2),
        .FRAME_PIXELS      (FP)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [BPP:0] q[$];
    bit         m_run, m_primed, m_err;
    int         m_cnt, m_uf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input bit keep_uf);
        q.delete();
        m_run = 0; m_primed = 0; m_err = 0; m_cnt = 0;
        if (!keep_uf) m_uf = 0;
    endtask

    function automatic bit exp_rdy();
        return !m_run || q.size() < DEPTH;
    endfunction

    task automatic check_outputs(input string tag);
        logic [BPP:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".level"},  32'(vif.level), q.size());
        chk({tag, ".tvalid"}, 32'(vif.out_axis_tvalid), 32'(q.size() != 0));
        chk({tag, ".tdata"},  32'(vif.out_axis_tdata), 32'(head[BPP-1:0]));
        chk({tag, ".tuser"},  32'(vif.out_axis_tuser), 32'(head[BPP]));
        chk({tag, ".tready"}, 32'(vif.in_axis_tready), 32'(exp_rdy()));
        chk({tag, ".ferr"},   32'(vif.frame_err), 32'(m_err));
        chk({tag, ".ufcnt"},  32'(vif.underflow_cnt), m_uf);
    endtask

    // Check current outputs, advance the model by one edge, then step the clock.
    task automatic tick(input string tag);
        bit pop, rdy, err;
        check_outputs(tag);
        rdy = exp_rdy();
        pop = (q.size() != 0) && vif.out_axis_tready;
        err = 0;
        if (m_run && m_primed && vif.out_axis_tready && q.size() == 0 && m_uf < 255) m_uf++;
        if (vif.sync_req) begin
            model_reset(1);
        end else begin
            if (pop) begin
                void'(q.pop_front());
                if (m_run) m_primed = 1;
            end
            if (vif.in_axis_tvalid && rdy) begin
                if (!m_run) begin
                    if (vif.in_axis_tuser) begin
                        q.push_back({vif.in_axis_tuser, vif.in_axis_tdata});
                        m_cnt = 1; m_run = 1;
                    end
                end else if (vif.in_axis_tuser) begin
                    if (m_cnt != FP) err = 1;
                    q.push_back({vif.in_axis_tuser, vif.in_axis_tdata});
                    m_cnt = 1;
                end else if (m_cnt == FP) begin
                    err = 1; m_run = 0; m_primed = 0;
                end else begin
                    q.push_back({vif.in_axis_tuser, vif.in_axis_tdata});
                    m_cnt++;
                end
            end
        end
        m_err = err;
        @(posedge clk); #1;
    endtask

    task automatic beat(input bit sof, input logic [BPP-1:0] d);
        vif.in_axis_tvalid = 1'b1;
        vif.in_axis_tuser  = sof;
        vif.in_axis_tdata  = d;
        tick("beat");
        vif.in_axis_tvalid = 1'b0;
        vif.in_axis_tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    initial begin
        vif.in_axis_tvalid  = 1'b0;
        vif.in_axis_tdata   = '0;
        vif.in_axis_tuser   = 1'b0;
        vif.out_axis_tready = 1'b0;
        vif.sync_req        = 1'b0;
        model_reset(0);

        @(posedge clk); #1;
        check_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // SOF alignment: leading non-SOF beats discarded
        for (int i = 0; i < 3; i++) beat(1'b0, 24'hA0A000 + 24'(i));
        beat(1'b1, 24'h112233);
        chk("sof.tvalid", 32'(vif.out_axis_tvalid), 32'd1);
        chk("sof.tdata",  32'(vif.out_axis_tdata), 32'h112233);
        chk("sof.tuser",  32'(vif.out_axis_tuser), 32'd1);
        chk("sof.level",  32'(vif.level), 32'd1);

        // fill to full with the encoder stalled, then drain in order
        for (int i = 1; i < DEPTH; i++) beat(i % FP == 0, 24'h100000 + 24'(i));
        chk("full.tready", 32'(vif.in_axis_tready), 32'd0);
        chk("full.level",  32'(vif.level), 32'd16);
        vif.out_axis_tready = 1'b1;
        idle(DEPTH);
        chk("drain.level", 32'(vif.level), 32'd0);

        // early SOF restart
        beat(1'b1, 24'h200000);
        for (int i = 1; i <= 6; i++) beat(1'b0, 24'h200000 + 24'(i));
        beat(1'b1, 24'h2000FF);
        chk("early.ferr",  32'(vif.frame_err), 32'd1);
        chk("early.tuser", 32'(vif.out_axis_tuser), 32'd1);
        chk("early.tdata", 32'(vif.out_axis_tdata), 32'h2000FF);
        idle(1);
        chk("early.ferr_clr", 32'(vif.frame_err), 32'd0);

        // overlong frame: 9th beat dropped, resync on next SOF
        for (int i = 1; i <= 7; i++) beat(1'b0, 24'h300000 + 24'(i));
        beat(1'b0, 24'hDEAD09);
        chk("long.ferr", 32'(vif.frame_err), 32'd1);
        beat(1'b0, 24'hDEAD0A);
        beat(1'b0, 24'hDEAD0B);
        beat(1'b1, 24'h400000);
        chk("resync.tuser", 32'(vif.out_axis_tuser), 32'd1);
        chk("resync.tdata", 32'(vif.out_axis_tdata), 32'h400000);

        // underflow saturation
        idle(300);
        chk("uf.sat", 32'(vif.underflow_cnt), 32'd255);

        // sync_req with level 5 and a simultaneous push
        vif.out_axis_tready = 1'b0;
        for (int i = 1; i <= 5; i++) beat(1'b0, 24'h500000 + 24'(i));
        chk("presync.level", 32'(vif.level), 32'd5);
        vif.in_axis_tvalid = 1'b1;
        vif.in_axis_tdata  = 24'h5000AA;
        vif.sync_req       = 1'b1;
        tick("sync");
        vif.sync_req       = 1'b0;
        vif.in_axis_tvalid = 1'b0;
        chk("sync.level",  32'(vif.level), 32'd0);
        chk("sync.tvalid", 32'(vif.out_axis_tvalid), 32'd0);
        chk("sync.ufcnt",  32'(vif.underflow_cnt), 32'd255);
        beat(1'b0, 24'h600001);
        chk("sync.drop", 32'(vif.level), 32'd0);
        beat(1'b1, 24'h600000);
        chk("sync.sof", 32'(vif.level), 32'd1);

        // asynchronous reset mid-frame
        beat(1'b0, 24'h600002);
        beat(1'b0, 24'h600003);
        #2 resetn = 1'b0;
        #1;
        model_reset(0);
        check_outputs("rst_mid");
        @(posedge clk); #1;
        resetn = 1'b1;
        beat(1'b0, 24'h700001);
        chk("rst.drop", 32'(vif.level), 32'd0);
        beat(1'b1, 24'h700000);
        vif.out_axis_tready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
